// File: rtl/readpoly_stream.sv
// readpoly_stream: reads N coefficients from the coefficient RAM starting at
// base_addr and streams them in ascending order on a valid/ready port. A small
// FIFO absorbs the one-cycle RAM latency and downstream backpressure; reads are
// only issued when the FIFO is guaranteed to have room for the returning word.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | waiting for start; FIFO empty, no reads outstanding
//   S_READ  | issuing RAM reads as FIFO credit allows
//   S_DRAIN | all N reads issued; waiting for the last coefficient handshake
module readpoly_stream #(
   parameter int DATA_W = 26,
   parameter int ADDR_W = 11,
   parameter int N      = 761,
   parameter int FIFO_D = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [ADDR_W-1:0] mem_address_i,
   output logic              mem_read_enable,
   input  logic [DATA_W-1:0] mem_output,
   output logic [DATA_W-1:0] coef_data,
   output logic [ADDR_W-1:0] coef_index,
   output logic              coef_valid,
   input  logic              coef_ready,
   output logic              busy,
   output logic              done
);

   localparam int PTR_W = $clog2(FIFO_D);
   localparam int CNT_W = PTR_W + 1;
   localparam int CRD_W = PTR_W + 2;
   localparam int K_W   = ADDR_W + 1;

   localparam logic [K_W-1:0]    N_K      = K_W'(N);
   localparam logic [ADDR_W-1:0] LAST_K   = ADDR_W'(N - 1);
   localparam logic [CRD_W-1:0]  FIFO_LIM = CRD_W'(FIFO_D);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [K_W-1:0]      rd_k_q, rd_k_d;
   logic [ADDR_W-1:0]   out_k_q, out_k_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                ren_q, ren_d;
   logic                pend_q, pend_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    fifo_cnt_q, fifo_cnt_d;
   logic [DATA_W-1:0]   fifo_mem_q [FIFO_D];
   logic [DATA_W-1:0]   fifo_mem_d [FIFO_D];

   logic                push;
   logic                pop;
   logic [CRD_W-1:0]    credit;
   logic                can_issue;

   assign coef_valid = (fifo_cnt_q != '0);
   assign pop        = coef_valid && coef_ready;
   // pend_q marks the cycle in which mem_output carries data for a read issued
   // in the previous cycle; it is cleared by reset, so stale returns are dropped.
   assign push       = pend_q;

   // Words that may still land in the FIFO: stored, returning now, returning
   // next cycle. A new read is safe only if it cannot overflow the FIFO.
   assign credit    = CRD_W'(fifo_cnt_q) + CRD_W'(pend_q) + CRD_W'(ren_q) - CRD_W'(pop);
   assign can_issue = (credit < FIFO_LIM);

   assign mem_address_i   = addr_q;
   assign mem_read_enable = ren_q;
   assign coef_data       = fifo_mem_q[rd_ptr_q];
   assign coef_index      = out_k_q;
   assign busy            = busy_q;
   assign done            = done_q;

   // Next-state logic: FIFO push/pop, read issue and sequencing FSM.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      rd_k_d     = rd_k_q;
      out_k_d    = out_k_q;
      addr_d     = addr_q;
      ren_d      = 1'b0;
      pend_d     = ren_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_cnt_d = fifo_cnt_q;
      fifo_mem_d = fifo_mem_q;

      if (push) begin
         fifo_mem_d[wr_ptr_q] = mem_output;
         wr_ptr_d             = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
         out_k_d  = out_k_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
         2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
         default: fifo_cnt_d = fifo_cnt_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               // The first read goes out on the accepting edge so that the
               // address is on the RAM port in the very next cycle.
               state_d = (N_K == K_W'(1)) ? S_DRAIN : S_READ;
               base_d  = base_addr;
               addr_d  = base_addr;
               ren_d   = 1'b1;
               rd_k_d  = K_W'(1);
               out_k_d = '0;
               busy_d  = 1'b1;
            end
         end
         S_READ: begin
            if (can_issue) begin
               ren_d  = 1'b1;
               addr_d = base_q + rd_k_q[ADDR_W-1:0];
               rd_k_d = rd_k_q + 1'b1;
               if ((rd_k_q + 1'b1) == N_K) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (pop && (out_k_q == LAST_K)) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State, counter, FIFO and output registers; reset flushes everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         base_q     <= '0;
         rd_k_q     <= '0;
         out_k_q    <= '0;
         addr_q     <= '0;
         ren_q      <= 1'b0;
         pend_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
         for (int i = 0; i < FIFO_D; i++) begin
            fifo_mem_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         rd_k_q     <= rd_k_d;
         out_k_q    <= out_k_d;
         addr_q     <= addr_d;
         ren_q      <= ren_d;
         pend_q     <= pend_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_cnt_q <= fifo_cnt_d;
         for (int i = 0; i < FIFO_D; i++) begin
            fifo_mem_q[i] <= fifo_mem_d[i];
         end
      end
   end

endmodule

// File: tb/tb_readpoly_stream.sv
// Testbench for readpoly_stream: RAM model with word a = a+100, directed
// passes with several ready patterns, a cycle-exact timing table for the
// full-rate pass, start-while-busy and asynchronous reset mid-pass.
module tb_readpoly_stream;

   localparam int DATA_W = 26;
   localparam int ADDR_W = 11;
   localparam int N      = 761;
   localparam int FIFO_D = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [ADDR_W-1:0] base_addr = '0;
   logic [ADDR_W-1:0] mem_address_i;
   logic              mem_read_enable;
   logic [DATA_W-1:0] mem_output = '0;
   logic [DATA_W-1:0] coef_data;
   logic [ADDR_W-1:0] coef_index;
   logic              coef_valid;
   logic              coef_ready = 1'b0;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] ram [2048];

   int tests = 0;
   int fails = 0;

   typedef struct {
      int                cyc;
      logic              ren;
      logic [ADDR_W-1:0] addr;
      logic              valid;
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
      logic              busy;
      logic              done;
      logic              chk_d;
   } vec_t;

   vec_t tab [10];

   readpoly_stream #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .N      (N),
      .FIFO_D (FIFO_D)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start),
      .base_addr       (base_addr),
      .mem_address_i   (mem_address_i),
      .mem_read_enable (mem_read_enable),
      .mem_output      (mem_output),
      .coef_data       (coef_data),
      .coef_index      (coef_index),
      .coef_valid      (coef_valid),
      .coef_ready      (coef_ready),
      .busy            (busy),
      .done            (done)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      if (mem_read_enable) mem_output <= ram[mem_address_i];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_addr"},  32'(mem_address_i),   0);
      chk({tag, "_ren"},   32'(mem_read_enable), 0);
      chk({tag, "_data"},  32'(coef_data),       0);
      chk({tag, "_index"}, 32'(coef_index),      0);
      chk({tag, "_valid"}, 32'(coef_valid),      0);
      chk({tag, "_busy"},  32'(busy),            0);
      chk({tag, "_done"},  32'(done),            0);
   endtask

   task automatic check_vec(input vec_t v);
      chk($sformatf("tab_c%0d_ren", v.cyc),   32'(mem_read_enable), 32'(v.ren));
      chk($sformatf("tab_c%0d_addr", v.cyc),  32'(mem_address_i),   32'(v.addr));
      chk($sformatf("tab_c%0d_valid", v.cyc), 32'(coef_valid),      32'(v.valid));
      chk($sformatf("tab_c%0d_busy", v.cyc),  32'(busy),            32'(v.busy));
      chk($sformatf("tab_c%0d_done", v.cyc),  32'(done),            32'(v.done));
      if (v.chk_d) begin
         chk($sformatf("tab_c%0d_index", v.cyc), 32'(coef_index), 32'(v.idx));
         chk($sformatf("tab_c%0d_data", v.cyc),  32'(coef_data),  32'(v.data));
      end
   endtask

   // One read pass. mode 0: ready high; 1: ready every third cycle;
   // 2: ready low until cycle 40. c2 >= 0 re-pulses start with base2.
   task automatic run_pass(input logic [ADDR_W-1:0] base, input int mode,
                           input bit use_tab, input int c2,
                           input logic [ADDR_W-1:0] base2);
      int                c, k_out, n_rd, dones, done_c, ed;
      bit                stalled;
      logic [DATA_W-1:0] held_d;
      logic [ADDR_W-1:0] held_i;
      logic [ADDR_W-1:0] ea;
      c = 0; k_out = 0; n_rd = 0; dones = 0; done_c = 0; stalled = 0;
      held_d = '0; held_i = '0;
      while (c < 4000) begin
         start     = (c == 0) || (c == c2);
         base_addr = (c == c2) ? base2 : base;
         case (mode)
            1:       coef_ready = (c % 3 == 0);
            2:       coef_ready = (c >= 40);
            default: coef_ready = 1'b1;
         endcase
         if (use_tab) begin
            foreach (tab[i]) if (tab[i].cyc == c) check_vec(tab[i]);
         end
         if (mode == 2 && c == 39) begin
            chk("stall_reads_issued", 32'(n_rd), 4);
            chk("stall_ren_low", 32'(mem_read_enable), 0);
         end
         if (mem_read_enable) begin
            ea = base + ADDR_W'(n_rd);
            chk("rd_addr", 32'(mem_address_i), 32'(ea));
            n_rd++;
         end
         chk("outstanding_le_fifo_d", 32'((n_rd - k_out) <= FIFO_D), 1);
         if (stalled) begin
            chk("stall_data_hold", 32'(coef_data), 32'(held_d));
            chk("stall_index_hold", 32'(coef_index), 32'(held_i));
         end
         if (coef_valid && coef_ready) begin
            ed = ((int'(base) + k_out) % 2048) + 100;
            chk("hs_index", 32'(coef_index), 32'(k_out));
            chk("hs_data", 32'(coef_data), 32'(ed));
            k_out++;
         end
         stalled = coef_valid && !coef_ready;
         held_d  = coef_data;
         held_i  = coef_index;
         if (done) begin
            dones++;
            done_c = c;
            chk("done_busy_low", 32'(busy), 0);
            chk("done_all_delivered", 32'(k_out), N);
         end
         if (dones > 0 && c >= done_c + 3) break;
         tick;
         c++;
      end
      start = 1'b0;
      chk("pass_completed", 32'(dones > 0), 1);
      chk("done_pulses", 32'(dones), 1);
      chk("reads_total", 32'(n_rd), N);
      chk("handshakes_total", 32'(k_out), N);
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) ram[i] = DATA_W'(i + 100);

      //           cyc  ren   addr      valid idx       data       busy  done  chk_d
      tab[0] = '{0,   1'b0, 11'd0,   1'b0, 11'd0,   26'd0,   1'b0, 1'b0, 1'b0};
      tab[1] = '{1,   1'b1, 11'd0,   1'b0, 11'd0,   26'd0,   1'b1, 1'b0, 1'b0};
      tab[2] = '{2,   1'b1, 11'd1,   1'b0, 11'd0,   26'd0,   1'b1, 1'b0, 1'b0};
      tab[3] = '{3,   1'b1, 11'd2,   1'b1, 11'd0,   26'd100, 1'b1, 1'b0, 1'b1};
      tab[4] = '{4,   1'b1, 11'd3,   1'b1, 11'd1,   26'd101, 1'b1, 1'b0, 1'b1};
      tab[5] = '{761, 1'b1, 11'd760, 1'b1, 11'd758, 26'd858, 1'b1, 1'b0, 1'b1};
      tab[6] = '{762, 1'b0, 11'd760, 1'b1, 11'd759, 26'd859, 1'b1, 1'b0, 1'b1};
      tab[7] = '{763, 1'b0, 11'd760, 1'b1, 11'd760, 26'd860, 1'b1, 1'b0, 1'b1};
      tab[8] = '{764, 1'b0, 11'd760, 1'b0, 11'd0,   26'd0,   1'b0, 1'b1, 1'b0};
      tab[9] = '{765, 1'b0, 11'd760, 1'b0, 11'd0,   26'd0,   1'b0, 1'b0, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick;
      tick;

      run_pass(11'd0,    0, 1'b1, -1, 11'd0);
      run_pass(11'd2040, 0, 1'b0, -1, 11'd0);
      run_pass(11'd5,    1, 1'b0, -1, 11'd0);
      run_pass(11'd100,  2, 1'b0, -1, 11'd0);
      run_pass(11'd300,  0, 1'b0, 10, 11'd77);

      // Asynchronous reset in the middle of a pass.
      start      = 1'b1;
      base_addr  = 11'd0;
      coef_ready = 1'b1;
      tick;
      start = 1'b0;
      repeat (49) tick;
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) begin
         tick;
         chk("post_rst_valid", 32'(coef_valid), 0);
         chk("post_rst_busy", 32'(busy), 0);
         chk("post_rst_ren", 32'(mem_read_enable), 0);
      end
      run_pass(11'd0, 0, 1'b1, -1, 11'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
